// File: rtl/pad_serial_tx_pkg.sv
// Shared types and idle-level constants for the pad serial transmitter.
// PARITY is always encoded so the state encoding matches with or without PAD_SERIAL_TX_PARITY_EN.
package pad_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  localparam logic O_IDLE    = 1'b1;
  localparam logic T_RELEASE = 1'b1;

  // Counter width that stays legal for a range of size 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_serial_tx_baud.sv
// Bit-time divider: counts 0..BIT_DIV-1 and flags the last clock of each bit.
module pad_serial_tx_baud
  import pad_serial_tx_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic C,
  input  logic R,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(BIT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge C) begin
    if (R || clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pad_serial_tx.sv
// Parallel-to-serial pad transmitter with registered O/T (OFDT-style output).
// Define PAD_SERIAL_TX_PARITY_EN to append an even-parity bit before STOP.
module pad_serial_tx
  import pad_serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 4,
  parameter int LEAD_BITS = 1
) (
  input  logic              C,
  input  logic              R,
  input  logic [DATA_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic              O,
  output logic              T,
  output logic              BUSY,
  output logic              DONE,
  output state_e            state_dbg
);

  localparam int IDX_W = cnt_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [3:0]       LAST_LEAD = 4'(LEAD_BITS - 1);

  // Handshake: a word transfers on a rising C edge where VALID and READY are
  // both high; READY is high only in IDLE with R low, so reset blocks accept.
  state_e            state;
  logic              tick;
  logic              accept;
  logic [3:0]        lead_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_next;
`ifdef PAD_SERIAL_TX_PARITY_EN
  logic              par;
`endif

  assign READY     = (state == ST_IDLE) && !R;
  assign accept    = VALID && READY;
  assign sh_next   = sh >> 1;
  assign state_dbg = state;

  pad_serial_tx_baud #(.BIT_DIV(BIT_DIV)) u_baud (
    .C    (C),
    .R    (R),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state    <= ST_IDLE;
      O        <= O_IDLE;
      T        <= T_RELEASE;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      lead_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
`ifdef PAD_SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sh       <= DATA;
            BUSY     <= 1'b1;
            T        <= 1'b0;
            lead_cnt <= '0;
            bit_idx  <= '0;
`ifdef PAD_SERIAL_TX_PARITY_EN
            par      <= ^DATA;
`endif
            if (LEAD_BITS == 0) begin
              state <= ST_START;
              O     <= 1'b0;
            end else begin
              state <= ST_LEAD;
              O     <= 1'b1;
            end
          end
        end
        ST_LEAD: begin
          if (tick) begin
            if (lead_cnt == LAST_LEAD) begin
              state <= ST_START;
              O     <= 1'b0;
            end else begin
              lead_cnt <= lead_cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            O     <= sh[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef PAD_SERIAL_TX_PARITY_EN
              state <= ST_PARITY;
              O     <= par;
`else
              state <= ST_STOP;
              O     <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sh      <= sh_next;
              O       <= sh_next[0];
            end
          end
        end
`ifdef PAD_SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            O     <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
            O     <= O_IDLE;
            T     <= T_RELEASE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          O     <= O_IDLE;
          T     <= T_RELEASE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
